operand_fwd_unit: RTL and testbench
===================================

Name: operand_fwd_unit

Overview:
- Forwarding and hazard-control unit in the decode/ID-EX boundary, directly upstream of the EX-stage operand muxes.
- Keeps a 2-deep history of in-flight register writers and compares each decoding instruction's sources against it.
- Registers per-operand hazard flags and 3-bit forward selects so they arrive at EX together with the instruction.
- Raises a load-use stall when forwarding cannot cover the dependency.

Parameters:
- REG_BITS, 4: register index width.
- HI_REG, 0: register that receives the upper 16 bits of a wide (32-bit) result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode slot holds a real instruction.
- id_src_a  in  REG_BITS  operand A source register.
- id_src_b  in  REG_BITS  operand B source register.
- id_uses_b  in  1  operand B comes from the register file (ALUSRC=0).
- id_dest  in  REG_BITS  destination register.
- id_wr_en  in  1  instruction writes id_dest (low half).
- id_wide  in  1  instruction also writes the upper 16 bits to HI_REG.
- id_is_load  in  1  instruction is a load; data is unavailable until the MEM stage.
- flush  in  1  squash the decode slot and all history.
- stall  out  1  combinational load-use stall to fetch/decode.
- ex_hazard_a  out  1  registered; operand A is forwarded in EX.
- ex_fwd_a  out  3  registered operand A select.
- ex_hazard_b  out  1  registered; operand B is forwarded in EX.
- ex_fwd_b  out  3  registered operand B select.

Behaviour:
- Select encoding: 000 none; 001 Btb[15:0]; 010 Btb[31:16]; 011 oneAway[15:0]; 100 oneAway[31:16].
  - Btb is the result of the instruction one ahead (entry E).
  - oneAway is the result of the instruction two ahead (entry M).
- History entries E and M each hold: valid, dest, wr_en, wide, is_load.
- Match for source s against entry X:
  - lo_hit = X.valid & X.wr_en & (X.dest==s).
  - hi_hit = X.valid & X.wide & (HI_REG==s).
  - If both hit, hi_hit wins.
- Priority: E over M. E hits give 001/010; else M hits give 011/100; else 000 with hazard 0.
- Operand B is evaluated only when id_uses_b=1; otherwise hazard_b=0 and fwd_b=000.
- stall = id_valid & E.is_load & (any A hit on E, or B hit on E with id_uses_b). A wide load counts via hi_hit as well.
- Per-cycle update, in priority order:
  - flush: E, M and all registered outputs cleared next edge.
  - stall: M<=E; E<=bubble (valid=0); outputs<=0. The decode instruction is held upstream and re-evaluated next cycle; it then sees the load in M and gets 011/100.
  - normal: M<=E; E<=decode fields (valid=id_valid); registered outputs<=computed values. If id_valid=0, outputs are 0.
- Latency: one cycle from decode inputs to ex_* outputs. stall has zero latency (combinational).
- Reset (rst_n=0, asynchronous): E.valid=M.valid=0, all ex_* outputs 0, stall=0.
  - Reset asserted mid-stall drops the stall immediately.
  - First edge after release behaves as normal with empty history.
- Simultaneous flush and stall condition: flush wins; stall output is still driven combinationally that cycle, and upstream treats flush as dominant.

Optional Feature:
FWD_STATS_EN
- Defined: adds outputs fwd_count[15:0] and stall_count[15:0].
  - fwd_count increments once per normal-update cycle in which either operand receives a nonzero select.
  - stall_count increments each stall cycle.
  - Both saturate at 16'hFFFF, clear on reset, and do not clear on flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Back-to-back: `ADD R3` then `SUB` with src_a=R3 -> next cycle ex_hazard_a=1, ex_fwd_a=001.
- Two apart: write R5, unrelated instruction, then src_b=R5 with uses_b=1 -> ex_fwd_b=011. Same sequence with uses_b=0 -> hazard_b=0.
- Wide result: MUL wide dest=R2 (HI_REG=0), then src_a=R0, src_b=R2 -> fwd_a=010, fwd_b=001. If instead two apart -> 100 and 011.
- Load-use: `LW R4` then src_a=R4 -> stall=1 for one cycle, ex outputs 0. Next cycle stall=0 and ex_fwd_a=011.
- Priority: E and M both write R6, then src_a=R6 -> fwd_a=001. Flush with history loaded -> next-cycle outputs 0 and no later forwards from squashed entries.
- Async reset: assert rst_n=0 between edges while stall=1 -> stall and all ex_* outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fwd_unit.sv
// Operand forwarding and load-use hazard control at the ID/EX boundary.
// Optional FWD_STATS_EN macro adds saturating forward/stall event counters.
module operand_fwd_unit #(
    parameter int REG_BITS = 4,
    parameter int HI_REG   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_src_a,
    input  logic [REG_BITS-1:0] id_src_b,
    input  logic                id_uses_b,
    input  logic [REG_BITS-1:0] id_dest,
    input  logic                id_wr_en,
    input  logic                id_wide,
    input  logic                id_is_load,
    input  logic                flush,
    output logic                stall,
    output logic                ex_hazard_a,
    output logic [2:0]          ex_fwd_a,
    output logic                ex_hazard_b,
    output logic [2:0]          ex_fwd_b
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]         fwd_count,
    output logic [15:0]         stall_count
`endif
);

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_E_LO = 3'b001;
    localparam logic [2:0] SEL_E_HI = 3'b010;
    localparam logic [2:0] SEL_M_LO = 3'b011;
    localparam logic [2:0] SEL_M_HI = 3'b100;
    localparam logic [REG_BITS-1:0] HI_IDX = REG_BITS'(HI_REG);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] dest;
        logic                wr_en;
        logic                wide;
    } entry_t;

    // Load-ness only matters while the writer sits in E, so M does not keep it.
    entry_t e_q, m_q;
    logic   e_is_load_q;

    logic [2:0] sel_a, sel_b;
    logic       a_e_hit, b_e_hit, any_fwd;

    function automatic logic [2:0] fwd_sel(input logic [REG_BITS-1:0] s,
                                           input entry_t e, input entry_t m);
        logic e_lo, e_hi, m_lo, m_hi;
        e_lo = e.valid & e.wr_en & (e.dest == s);
        e_hi = e.valid & e.wide  & (HI_IDX == s);
        m_lo = m.valid & m.wr_en & (m.dest == s);
        m_hi = m.valid & m.wide  & (HI_IDX == s);
        if (e_hi)      return SEL_E_HI;
        else if (e_lo) return SEL_E_LO;
        else if (m_hi) return SEL_M_HI;
        else if (m_lo) return SEL_M_LO;
        else           return SEL_NONE;
    endfunction

    always_comb begin
        sel_a   = fwd_sel(id_src_a, e_q, m_q);
        sel_b   = id_uses_b ? fwd_sel(id_src_b, e_q, m_q) : SEL_NONE;
        a_e_hit = (sel_a == SEL_E_LO) || (sel_a == SEL_E_HI);
        b_e_hit = (sel_b == SEL_E_LO) || (sel_b == SEL_E_HI);
        any_fwd = id_valid && ((sel_a != SEL_NONE) || (sel_b != SEL_NONE));
        stall   = id_valid & e_q.valid & e_is_load_q & (a_e_hit | b_e_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= '0;
            m_q         <= '0;
            e_is_load_q <= 1'b0;
            ex_hazard_a <= 1'b0;
            ex_fwd_a    <= SEL_NONE;
            ex_hazard_b <= 1'b0;
            ex_fwd_b    <= SEL_NONE;
        end else if (flush) begin
            e_q         <= '0;
            m_q         <= '0;
            e_is_load_q <= 1'b0;
            ex_hazard_a <= 1'b0;
            ex_fwd_a    <= SEL_NONE;
            ex_hazard_b <= 1'b0;
            ex_fwd_b    <= SEL_NONE;
        end else if (stall) begin
            // Bubble into E; the held instruction will find the load in M.
            m_q         <= e_q;
            e_q         <= '0;
            e_is_load_q <= 1'b0;
            ex_hazard_a <= 1'b0;
            ex_fwd_a    <= SEL_NONE;
            ex_hazard_b <= 1'b0;
            ex_fwd_b    <= SEL_NONE;
        end else begin
            m_q         <= e_q;
            e_q.valid   <= id_valid;
            e_q.dest    <= id_dest;
            e_q.wr_en   <= id_wr_en;
            e_q.wide    <= id_wide;
            e_is_load_q <= id_is_load;
            ex_hazard_a <= id_valid && (sel_a != SEL_NONE);
            ex_fwd_a    <= id_valid ? sel_a : SEL_NONE;
            ex_hazard_b <= id_valid && (sel_b != SEL_NONE);
            ex_fwd_b    <= id_valid ? sel_b : SEL_NONE;
        end
    end

`ifdef FWD_STATS_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else if (!flush) begin
            if (stall) begin
                if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
            end else if (any_fwd) begin
                if (fwd_count != 16'hFFFF) fwd_count <= fwd_count + 16'd1;
            end
        end
    end
`else
    logic unused_any_fwd;
    assign unused_any_fwd = any_fwd;
`endif

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Scoreboard bench for operand_fwd_unit: directed decode sequences with
// hand-derived forward selects, load-use stalls, flush and async reset.
module tb_operand_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_src_a = '0;
    logic [3:0] id_src_b = '0;
    logic       id_uses_b = 1'b0;
    logic [3:0] id_dest = '0;
    logic       id_wr_en = 1'b0;
    logic       id_wide = 1'b0;
    logic       id_is_load = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic       ex_hazard_a, ex_hazard_b;
    logic [2:0] ex_fwd_a, ex_fwd_b;

    int checks = 0;
    int errors = 0;

    // Expected EX word: {hazard_a, fwd_a, hazard_b, fwd_b}
    logic [7:0] exp_q[$];

    operand_fwd_unit #(.REG_BITS(4), .HI_REG(0)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src_a(id_src_a), .id_src_b(id_src_b), .id_uses_b(id_uses_b),
        .id_dest(id_dest), .id_wr_en(id_wr_en), .id_wide(id_wide),
        .id_is_load(id_is_load), .flush(flush), .stall(stall),
        .ex_hazard_a(ex_hazard_a), .ex_fwd_a(ex_fwd_a),
        .ex_hazard_b(ex_hazard_b), .ex_fwd_b(ex_fwd_b)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [7:0] ex_word();
        return {ex_hazard_a, ex_fwd_a, ex_hazard_b, ex_fwd_b};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // monitor: one registered EX word per cycle that had stimulus issued
    always @(posedge clk) begin
        if (exp_q.size() != 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            #1;
            check("ex_out", ex_word(), e);
        end
    end

    // driver: apply one decode cycle, check stall, push expected EX word
    task automatic issue(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic ub, input logic [3:0] d, input logic wr,
                         input logic wd, input logic ld, input logic fl,
                         input logic exp_stall, input logic [7:0] exp_out);
        @(negedge clk);
        id_valid = v; id_src_a = a; id_src_b = b; id_uses_b = ub;
        id_dest = d; id_wr_en = wr; id_wide = wd; id_is_load = ld; flush = fl;
        #1;
        check("stall", {7'd0, stall}, {7'd0, exp_stall});
        exp_q.push_back(exp_out);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected bench to end");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        // reset state
        #2;
        check("reset_out", ex_word(), 8'h00);
        check("reset_stall", {7'd0, stall}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        //     v  a  b  ub d  wr wd ld fl  stall expected {ha,fa,hb,fb}
        issue(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, {1'b0, 3'b000, 1'b0, 3'b000}); // ADD R3
        issue(1, 3, 1, 1, 7, 1, 0, 0, 0, 0, {1'b1, 3'b001, 1'b0, 3'b000}); // back-to-back
        issue(1, 8, 9, 1, 5, 1, 0, 0, 0, 0, 8'h00);                        // write R5
        issue(1,10,11, 1,12, 1, 0, 0, 0, 0, 8'h00);                        // unrelated
        issue(1, 9, 5, 1,13, 1, 0, 0, 0, 0, {1'b0, 3'b000, 1'b1, 3'b011}); // two apart B
        issue(1, 9, 9, 1, 5, 1, 0, 0, 0, 0, 8'h00);
        issue(1,10,11, 1,12, 1, 0, 0, 0, 0, 8'h00);
        issue(1, 9, 5, 0,14, 1, 0, 0, 0, 0, 8'h00);                        // uses_b=0
        issue(1, 1, 1, 1, 2, 1, 1, 0, 0, 0, 8'h00);                        // MUL wide R2
        issue(1, 0, 2, 1,15, 1, 0, 0, 0, 0, {1'b1, 3'b010, 1'b1, 3'b001}); // wide, E
        issue(1, 0, 2, 1,11, 1, 0, 0, 0, 0, {1'b1, 3'b100, 1'b1, 3'b011}); // wide, M
        issue(1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 8'h00);                        // MUL wide R0
        issue(1, 0, 3, 1, 9, 1, 0, 0, 0, 0, {1'b1, 3'b010, 1'b0, 3'b000}); // hi beats lo
        issue(1, 1, 1, 1, 6, 1, 0, 0, 0, 0, 8'h00);                        // R6 -> M
        issue(1, 1, 1, 1, 6, 1, 0, 0, 0, 0, 8'h00);                        // R6 -> E
        issue(1, 6, 6, 0, 3, 1, 0, 0, 0, 0, {1'b1, 3'b001, 1'b0, 3'b000}); // E priority
        issue(1, 1, 1, 0, 4, 1, 0, 1, 0, 0, 8'h00);                        // LW R4
        issue(1, 4, 1, 1, 8, 1, 0, 0, 0, 1, 8'h00);                        // load-use stall
        issue(1, 4, 1, 1, 8, 1, 0, 0, 0, 0, {1'b1, 3'b011, 1'b0, 3'b000}); // replay
        issue(1, 1, 1, 0, 4, 1, 0, 1, 0, 0, 8'h00);                        // LW R4
        issue(1, 1, 4, 0, 9, 1, 0, 0, 0, 0, 8'h00);                        // B unused: no stall
        issue(1, 1, 1, 1, 5, 1, 1, 1, 0, 0, 8'h00);                        // wide LW R5
        issue(1, 2, 0, 1,10, 1, 0, 0, 0, 1, 8'h00);                        // hi stall
        issue(1, 2, 0, 1,10, 1, 0, 0, 0, 0, {1'b0, 3'b000, 1'b1, 3'b100}); // replay
        issue(1, 1, 1, 1, 6, 1, 0, 0, 0, 0, 8'h00);                        // R6
        issue(1, 6, 1, 1, 7, 1, 0, 0, 1, 0, 8'h00);                        // flush
        issue(1, 6,10, 1, 1, 1, 0, 0, 0, 0, 8'h00);                        // squashed
        issue(1, 6,10, 1, 2, 1, 0, 0, 0, 0, 8'h00);
        issue(1, 3, 3, 0, 4, 1, 0, 1, 0, 0, 8'h00);                        // LW R4
        issue(1, 4, 4, 0, 9, 1, 0, 0, 1, 1, 8'h00);                        // flush + stall
        issue(1, 4, 4, 0, 9, 1, 0, 0, 0, 0, 8'h00);                        // history empty
        issue(0, 9, 9, 1, 9, 1, 0, 0, 0, 0, 8'h00);                        // idle slot
        issue(1, 7, 7, 0, 3, 1, 0, 0, 0, 0, 8'h00);                        // ADD R3
        issue(1, 3, 3, 0, 4, 1, 0, 1, 0, 0, {1'b1, 3'b001, 1'b0, 3'b000}); // LW R4
        issue(1, 4, 4, 0, 8, 1, 0, 0, 0, 1, 8'h00);                        // stall high

        // async reset between edges while stalled
        #1;
        check("pre_reset_out", ex_word(), {1'b1, 3'b001, 1'b0, 3'b000});
        rst_n = 1'b0;
        #1;
        check("async_stall", {7'd0, stall}, 8'h00);
        check("async_out", ex_word(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 4, 3, 1, 5, 1, 0, 0, 0, 0, 8'h00);                        // empty history

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
